jog_setpoint_scheduler: RTL and testbench

- Consumes the single-cycle up/down jog pulses produced by the front-panel pulse generator.
- Maintains a bounded setpoint, with step acceleration on sustained same-direction jogging.
- Offers each new setpoint to the downstream motion/driver block over a valid/ready handshake.
- Coalesces jog events that arrive while an offer is outstanding, so the driver always receives the latest value and never a stale one.

---
 rtl/jog_setpoint_scheduler_if.sv | 11 +
 rtl/jog_setpoint_scheduler.sv | 146 ++++++++++++++
 tb/tb_jog_setpoint_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/jog_setpoint_scheduler_if.sv
// Setpoint offer channel between the jog scheduler and the downstream driver.
interface jog_setpoint_scheduler_if #(
  parameter int unsigned Width = 16
) ();
  logic             oValid;
  logic [Width-1:0] oValue;
  logic             iReady;

  modport master (output oValid, output oValue, input iReady);
  modport slave  (input oValid, input oValue, output iReady);
endinterface

// File: rtl/jog_setpoint_scheduler.sv
// Jog setpoint scheduler: bounded setpoint with step acceleration, offered
// downstream over valid/ready with coalescing of events during an offer.
module jog_setpoint_scheduler #(
  parameter int unsigned Width          = 16,
  parameter int unsigned MinValue       = 0,
  parameter int unsigned MaxValue       = 1000,
  parameter int unsigned InitValue      = 0,
  parameter int unsigned StepSmall      = 1,
  parameter int unsigned StepLarge      = 10,
  parameter int unsigned AccelCount     = 8,
  parameter int unsigned ClockPeriod_ns = 20,
  parameter int unsigned GapInterval_ns = 500_000_000
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       iEnable,
  input  logic                       iUp,
  input  logic                       iDown,
  jog_setpoint_scheduler_if.master   bus,
  output logic                       oAtMin,
  output logic                       oAtMax
);

  localparam int unsigned GapCycles = GapInterval_ns / ClockPeriod_ns;
  localparam int unsigned GapW      = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam int unsigned StreakW   = (AccelCount > 0) ? $clog2(AccelCount + 1) : 1;
  localparam int unsigned W1        = Width + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_OFFER = 2'b01} state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10} dir_t;

  state_t               state_q, state_d;
  dir_t                 dir_q, dir_d, ev_dir;
  logic [Width-1:0]     value_q, next_val, next_up, next_dn, ovalue_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [W1-1:0]        step, sum_up, floor_dn;
  logic                 pending_q, pending_d, ovalid_d;
  logic                 ev, changed;

  // Candidate setpoint for this edge, computed one bit wide so bounds never wrap.
  always_comb begin
    ev       = iEnable & (iUp ^ iDown);
    ev_dir   = iUp ? DIR_UP : DIR_DOWN;
    step     = ((dir_q == ev_dir) && (streak_q >= StreakW'(AccelCount)))
               ? W1'(StepLarge) : W1'(StepSmall);
    sum_up   = W1'(value_q) + step;
    floor_dn = W1'(MinValue) + step;
    next_up  = (sum_up > W1'(MaxValue)) ? Width'(MaxValue) : sum_up[Width-1:0];
    next_dn  = (W1'(value_q) < floor_dn) ? Width'(MinValue) : value_q - step[Width-1:0];
    next_val = value_q;
    if (ev) next_val = iUp ? next_up : next_dn;
    changed  = ev & (next_val != value_q);
  end

  // Direction streak and idle-gap tracking for acceleration.
  always_comb begin
    streak_d = streak_q;
    dir_d    = dir_q;
    gap_d    = gap_q;
    if (!iEnable) begin
      streak_d = '0;
      gap_d    = '0;
    end else if (ev) begin
      gap_d = '0;
      if (dir_q == ev_dir) begin
        if (streak_q < StreakW'(AccelCount)) streak_d = streak_q + 1'b1;
      end else begin
        streak_d = StreakW'(1);
        dir_d    = ev_dir;
      end
    end else begin
      if (iUp & iDown) streak_d = '0;
      if (gap_q >= GapW'(GapCycles - 1)) begin
        streak_d = '0;
        dir_d    = DIR_NONE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // Offer FSM: next state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    ovalid_d  = bus.oValid;
    ovalue_d  = bus.oValue;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        if (changed) begin
          ovalid_d = 1'b1;
          ovalue_d = next_val;
          state_d  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (bus.oValid && bus.iReady) begin
          if (pending_q || changed) begin
            ovalue_d  = next_val;
            pending_d = 1'b0;
          end else begin
            ovalid_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else if (changed) begin
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ovalid_d  = 1'b0;
        pending_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_NONE;
      value_q    <= Width'(InitValue);
      streak_q   <= '0;
      gap_q      <= '0;
      pending_q  <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oValue <= Width'(InitValue);
      oAtMin     <= (Width'(InitValue) == Width'(MinValue));
      oAtMax     <= (Width'(InitValue) == Width'(MaxValue));
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      value_q    <= next_val;
      streak_q   <= streak_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      bus.oValid <= ovalid_d;
      bus.oValue <= ovalue_d;
      oAtMin     <= (next_val == Width'(MinValue));
      oAtMax     <= (next_val == Width'(MaxValue));
    end
  end

endmodule

// File: tb/tb_jog_setpoint_scheduler.sv
// Self-checking bench for jog_setpoint_scheduler: cycle model plus directed tests.
module tb_jog_setpoint_scheduler;

  localparam int MIN = 0, MAX = 20, INIT = 5, SS = 1, SL = 5, ACC = 3, GAP = 10;

  logic Clock, Reset, iEnable, iUp, iDown, oAtMin, oAtMax;
  jog_setpoint_scheduler_if #(.Width(8)) bus ();

  jog_setpoint_scheduler #(
    .Width(8), .MinValue(MIN), .MaxValue(MAX), .InitValue(INIT),
    .StepSmall(SS), .StepLarge(SL), .AccelCount(ACC),
    .ClockPeriod_ns(20), .GapInterval_ns(200)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iUp(iUp), .iDown(iDown),
    .bus(bus), .oAtMin(oAtMin), .oAtMax(oAtMax)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  int acc[$];

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: integer setpoint with clamping, streak and offer state.
  int  mval, mstreak, mdir, mgap, moff, step, nv, d;
  bit  mvalid, mpend, mready, ev, ch;

  always @(posedge Clock) begin
    if (Reset) begin
      mval = INIT; moff = INIT; mstreak = 0; mdir = 0; mgap = 0;
      mvalid = 0; mpend = 0; mready = 1;
    end else if (mready) begin
      ev   = iEnable && (iUp != iDown);
      d    = iUp ? 1 : -1;
      step = (ev && mdir == d && mstreak >= ACC) ? SL : SS;
      nv   = mval;
      if (ev) begin
        nv = mval + d * step;
        if (nv > MAX) nv = MAX;
        if (nv < MIN) nv = MIN;
      end
      ch = (nv != mval);
      if (!iEnable) begin
        mstreak = 0; mgap = 0;
      end else if (ev) begin
        if (mdir == d) mstreak = (mstreak + 1 > ACC) ? ACC : mstreak + 1;
        else begin mstreak = 1; mdir = d; end
        mgap = 0;
      end else begin
        if (iUp && iDown) mstreak = 0;
        if (mgap >= GAP - 1) begin mstreak = 0; mdir = 0; end
        else mgap++;
      end
      if (!mvalid) begin
        if (ch) begin mvalid = 1; moff = nv; end
      end else if (bus.iReady) begin
        if (mpend || ch) begin moff = nv; mpend = 0; end
        else mvalid = 0;
      end else if (ch) begin
        mpend = 1;
      end
      mval = nv;
    end
  end

  // Per-cycle comparison against the model, and log of accepted offers.
  always @(negedge Clock) begin
    if (mready) begin
      check("oValid", 32'(bus.oValid), int'(mvalid));
      check("oValue", 32'(bus.oValue), moff);
      check("oAtMin", 32'(oAtMin), int'(mval == MIN));
      check("oAtMax", 32'(oAtMax), int'(mval == MAX));
      if (!Reset && bus.oValid && bus.iReady) acc.push_back(int'(bus.oValue));
    end
  end

  task automatic idle(input int n);
    iUp = 0; iDown = 0;
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic pulse(input bit up, input bit dn);
    iUp = up; iDown = dn;
    @(posedge Clock); #1;
    iUp = 0; iDown = 0;
  endtask

  task automatic do_reset();
    Reset = 1;
    @(posedge Clock); #1;
    Reset = 0;
  endtask

  task automatic check_acc(input string nm, input int base, input int e[$]);
    check($sformatf("%s count", nm), 32'(acc.size() - base), e.size());
    for (int i = 0; i < e.size(); i++)
      if (base + i < acc.size()) check($sformatf("%s[%0d]", nm, i), 32'(acc[base + i]), e[i]);
  endtask

  initial begin
    int base;
    int e[$];
    Reset = 1; iEnable = 1; iUp = 0; iDown = 0; bus.iReady = 1;
    repeat (2) @(posedge Clock);
    #1 Reset = 0;
    check("reset oValid", 32'(bus.oValid), 0);
    check("reset oValue", 32'(bus.oValue), INIT);

    // Single step
    base = acc.size();
    pulse(1, 0);
    check("t1 valid", 32'(bus.oValid), 1);
    check("t1 value", 32'(bus.oValue), 6);
    check("t1 atmax", 32'(oAtMax), 0);
    idle(1);
    check("t1 valid after", 32'(bus.oValid), 0);
    idle(2);
    e = '{6}; check_acc("t1 offers", base, e);

    // Acceleration, then gap restores small step
    do_reset();
    base = acc.size();
    repeat (5) begin pulse(1, 0); idle(1); end
    idle(12);
    pulse(1, 0); idle(3);
    e = '{6, 7, 8, 13, 18, 19}; check_acc("t2 offers", base, e);

    // Saturation at both bounds
    base = acc.size();
    pulse(1, 0); idle(1);
    check("t3 atmax", 32'(oAtMax), 1);
    pulse(1, 0); idle(2);
    repeat (7) begin pulse(0, 1); idle(1); end
    check("t3 atmin", 32'(oAtMin), 1);
    pulse(0, 1); idle(2);
    e = '{20, 19, 18, 17, 12, 7, 2, 0}; check_acc("t3 offers", base, e);

    // Backpressure coalescing
    do_reset();
    base = acc.size();
    bus.iReady = 0;
    repeat (3) begin pulse(1, 0); idle(1); end
    check("t4 held", 32'(bus.oValue), 6);
    bus.iReady = 1;
    idle(1);
    check("t4 coalesced", 32'(bus.oValue), 8);
    idle(1);
    check("t4 done", 32'(bus.oValid), 0);
    idle(2);
    e = '{6, 8}; check_acc("t4 offers", base, e);

    // Simultaneous, disabled, and transfer-with-event
    base = acc.size();
    pulse(1, 1); idle(2);
    pulse(1, 0); idle(2);
    iEnable = 0; pulse(1, 0); idle(2); iEnable = 1;
    pulse(1, 0); pulse(1, 0); idle(3);
    e = '{9, 10, 11}; check_acc("t5 offers", base, e);

    // Reset mid-offer
    do_reset();
    base = acc.size();
    bus.iReady = 0;
    pulse(1, 0); idle(2);
    check("t6 pending", 32'(bus.oValue), 6);
    do_reset();
    check("t6 valid", 32'(bus.oValid), 0);
    check("t6 value", 32'(bus.oValue), INIT);
    bus.iReady = 1;
    idle(6);
    e.delete(); check_acc("t6 offers", base, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
